enc_pipe_ctrl: RTL and testbench

//  Sequencer for the 12-round pipelined ENC post-processing cipher.
//  - Packs raw TRNG bits into 32-bit words and issues them into ENC.
//  - Tracks in-flight words and captures ENC results into an output FIFO with valid/ready.
//  - Performs safe key changes by draining the pipeline first.

---
 rtl/enc_pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_enc_pipe_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/enc_pipe_ctrl.sv
// enc_pipe_ctrl: packs TRNG bits into words, issues them to ENC, captures results in a FIFO
// and changes the ENC key only after draining. Define ENC_CTRL_STATS_EN to add drop_cnt.
module enc_pipe_ctrl #(
    parameter int         LATENCY    = 13,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] RESET_KEY  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_vld,
    input  logic [7:0]  key_in,
    input  logic        key_ld,
    output logic        key_busy,
    output logic [31:0] enc_d_in,
    output logic [7:0]  enc_k_in,
    input  logic [31:0] enc_d_out,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
`ifdef ENC_CTRL_STATS_EN
    ,
    output logic [15:0] drop_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD, SETTLE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        col_q, col_d, enc_d_in_q, enc_d_in_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [7:0]         key_q, key_d, pend_q, pend_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [AW:0]        fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [31:0]        mem [FIFO_DEPTH];
    logic [CW-1:0]      inflight;
    logic               issue, push, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
        // credit check counts every word already in flight, so the FIFO can never overflow
        issue = state_q == RUN && cnt_q == 6'd32 &&
                (CW'(fifo_cnt_q) + inflight) < CW'(FIFO_DEPTH);
        push  = vld_q[LATENCY-1];
        pop   = out_valid && out_ready;
        col_d = col_q;
        cnt_d = cnt_q;
        if (issue) begin
            col_d = {31'b0, bit_in};
            cnt_d = bit_vld ? 6'd1 : 6'd0;
        end else if (bit_vld && cnt_q != 6'd32) begin
            col_d = {col_q[30:0], bit_in};
            cnt_d = cnt_q + 6'd1;
        end
        enc_d_in_d = issue ? col_q : enc_d_in_q;
        vld_d      = {vld_q[LATENCY-2:0], issue};
        fifo_cnt_d = fifo_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_d       = push ? wr_q + AW'(1) : wr_q;
        rd_d       = pop ? rd_q + AW'(1) : rd_q;
        state_d    = state_q;
        pend_d     = pend_q;
        key_d      = key_q;
        case (state_q)
            RUN: if (key_ld) begin
                pend_d  = key_in;
                state_d = DRAIN;
            end
            DRAIN: if (inflight == '0) state_d = LOAD;
            LOAD: begin
                key_d   = pend_q;
                state_d = SETTLE;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            col_q      <= '0;
            cnt_q      <= '0;
            enc_d_in_q <= '0;
            key_q      <= RESET_KEY;
            pend_q     <= RESET_KEY;
            vld_q      <= '0;
            fifo_cnt_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            enc_d_in_q <= enc_d_in_d;
            key_q      <= key_d;
            pend_q     <= pend_d;
            vld_q      <= vld_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= enc_d_out;
        if (rst_n && push) assert (fifo_cnt_q != (AW+1)'(FIFO_DEPTH));
    end

    assign out_valid = fifo_cnt_q != '0;
    assign out_data  = out_valid ? mem[rd_q] : '0;
    assign key_busy  = state_q != RUN;
    assign enc_d_in  = enc_d_in_q;
    assign enc_k_in  = key_q;

`ifdef ENC_CTRL_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic        drop;

    always_comb begin
        drop   = bit_vld && cnt_q == 6'd32 && !issue;
        drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_enc_pipe_ctrl.sv
// tb_enc_pipe_ctrl: randomized scoreboard bench for enc_pipe_ctrl with a stand-in ENC pipeline.
// Checks drop_cnt as well when built with ENC_CTRL_STATS_EN.
module tb_enc_pipe_ctrl;
    localparam int LAT   = 13;
    localparam int DEPTH = 16;

    logic        clk = 0, rst_n = 0, bit_in = 0, bit_vld = 0, key_ld = 0, out_ready = 0;
    logic [7:0]  key_in = 0;
    logic        key_busy, out_valid;
    logic [31:0] enc_d_in, enc_d_out, out_data;
    logic [7:0]  enc_k_in;
`ifdef ENC_CTRL_STATS_EN
    logic [15:0] drop_cnt;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    enc_pipe_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .RESET_KEY(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
        .key_in(key_in), .key_ld(key_ld), .key_busy(key_busy),
        .enc_d_in(enc_d_in), .enc_k_in(enc_k_in), .enc_d_out(enc_d_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ENC_CTRL_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    function automatic logic [31:0] enc_f(input logic [31:0] d, input logic [7:0] k);
        return {d[26:0], d[31:27]} ^ {4{k}} ^ 32'h9E3779B9;
    endfunction

    // stand-in ENC: 12 register stages so the result sits on d_out before the 13th edge
    logic [31:0] st [12];
    always @(posedge clk) begin
        st[0] <= enc_f(enc_d_in, enc_k_in);
        for (int i = 1; i < 12; i++) st[i] <= st[i-1];
    end
    assign enc_d_out = st[11];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    // reference model: issue times kept as a queue, FIFO as an occupancy count, words as expectations
    logic [31:0] m_word = 0, m_din = 0;
    logic [7:0]  m_key = 0, m_pend = 0;
    int          m_cnt = 0, m_fifo = 0, m_drop = 0, m_key_at = -1, cyc = 0, infl;
    bit          m_busy = 0, cap, iss, pop;
    int          issued[$];
    logic [31:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_word = 0; m_din = 0; m_key = 0; m_pend = 0; m_cnt = 0; m_fifo = 0;
            m_drop = 0; m_key_at = -1; m_busy = 0; cyc = 0;
            issued.delete();
            exp_q.delete();
        end else begin
            infl = issued.size();
            cap  = infl > 0 && issued[0] == cyc - LAT;
            iss  = !m_busy && m_cnt == 32 && m_fifo + infl < DEPTH;
            pop  = m_fifo > 0 && out_ready;
            if (bit_vld && m_cnt == 32 && !iss && m_drop < 65535) m_drop++;
            if (iss) begin
                m_din = m_word;
                exp_q.push_back(enc_f(m_word, m_key));
                issued.push_back(cyc);
                m_cnt  = bit_vld ? 1 : 0;
                m_word = bit_vld ? 32'(bit_in) : 32'd0;
            end else if (bit_vld && m_cnt < 32) begin
                m_word = {m_word[30:0], bit_in};
                m_cnt++;
            end
            if (cap) void'(issued.pop_front());
            m_fifo = m_fifo + int'(cap) - int'(pop);
            if (m_busy) begin
                if (m_key_at < 0) begin
                    if (infl == 0) m_key_at = cyc + 1;
                end else if (cyc == m_key_at) m_key = m_pend;
                else begin
                    m_busy   = 0;
                    m_key_at = -1;
                end
            end else if (key_ld) begin
                m_busy = 1;
                m_pend = key_in;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("key_busy", 32'(key_busy), 32'(m_busy));
            chk("enc_k_in", 32'(enc_k_in), 32'(m_key));
            chk("enc_d_in", enc_d_in, m_din);
            chk("out_valid", 32'(out_valid), 32'(m_fifo > 0));
`ifdef ENC_CTRL_STATS_EN
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_unexpected", out_data, 32'hxxxxxxxx);
                else chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic bv, input logic b, input logic kl, input logic [7:0] k);
        @(posedge clk);
        #2;
        bit_vld = bv;
        bit_in  = b;
        key_ld  = kl;
        key_in  = k;
    endtask

    logic [31:0] pat = 32'hA5A50F0F;
    int          n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_enc_d_in", enc_d_in, 0);
        chk("rst_enc_k_in", 32'(enc_k_in), 0);
        chk("rst_key_busy", 32'(key_busy), 0);
        rst_n     = 1;
        out_ready = 1;
        for (int i = 31; i >= 0; i--) step(1, pat[i], 0, 0);
        step(0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("first_word", enc_d_in, 32'hA5A50F0F);
        repeat (20) step(0, 0, 0, 0);
        out_ready = 0;
        repeat (32 * 20) step(1, 1'($urandom), 0, 0);
        chk("full_fifo_valid", 32'(out_valid), 1);
        out_ready = 1;
        repeat (32 * 20) step(1, 1'($urandom), 0, 0);
        n = 0;
        while (!(issued.size() == 1 && !m_busy) && n < 200) begin
            step(1, 1'($urandom), 0, 0);
            n++;
        end
        chk("key_window_found", 32'(n < 200), 1);
        step(1, 1'($urandom), 1, 8'h3C);
        step(1, 1'($urandom), 0, 8'h00);
        step(1, 1'($urandom), 1, 8'h77);
        step(1, 1'($urandom), 0, 8'h00);
        repeat (40) step(1, 1'($urandom), 0, 0);
        chk("key_after_change", 32'(enc_k_in), 32'h3C);
        out_ready = 0;
        repeat (32 * 6) step(1, 1'($urandom), 0, 0);
        step(0, 0, 0, 0);
        #1;
        rst_n = 0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", out_data, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
        out_ready = 1;
        repeat (2 * LAT) step(0, 0, 0, 0);
        chk("post_rst_quiet", 32'(out_valid), 0);
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) out_ready = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 199) == 0,
                 8'($urandom));
        end
        out_ready = 1;
        n = 0;
        while ((exp_q.size() != 0 || m_busy) && n < 300) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
